tracker_sequencer: RTL
======================

// Module: tracker_sequencer
// PURPOSE
//  Sequences the two-axis (theta/phi) solar-tracker positioning that sits in front of control_movimiento.
//  Auto mode: samples the four LDR readings over a valid/ready handshake and steps each axis toward the brighter side.
//  Manual mode: steps each axis to an operator target.
//  Owns the actual-position registers and drives s, theta_actual and phi_actual into the motion datapath.
// PARAMETERS
//  DW          16     width of LDR readings, positions and targets
//  DEADBAND    4      |R1-R2| <= DEADBAND => axis holds
//  STEP_DIV    1000   clocks per step slot (>=2)
//  SETTLE_CYC  50000  clocks waited after an auto step pass before resampling (>=1)
//  THETA_MAX   180    theta upper limit in steps (lower limit 0)
//  PHI_MAX     90     phi upper limit in steps (lower limit 0)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  start           in   1   level; high = tracking enabled
//  mode_manual     in   1   1 = manual, 0 = auto; sampled only on IDLE exit
//  sens_valid      in   1   LDR sample valid
//  sens_ready      out  1   sequencer accepts sample (SAMPLE state only)
//  R_vertical_1    in   DW  LDR, theta+ side
//  R_vertical_2    in   DW  LDR, theta- side
//  R_horizontal_1  in   DW  LDR, phi+ side
//  R_horizontal_2  in   DW  LDR, phi- side
//  theta_manual    in   DW  manual theta target; sampled on IDLE exit
//  phi_manual      in   DW  manual phi target; sampled on IDLE exit
//  s               out  2   0 idle, 1 auto, 2 manual (3 unused)
//  theta_actual    out  DW  current theta position, steps
//  phi_actual      out  DW  current phi position, steps
//  step_theta_pos  out  1   1-cycle pulse, theta +1 step
//  step_theta_neg  out  1   1-cycle pulse, theta -1 step
//  step_phi_pos    out  1   1-cycle pulse, phi +1 step
//  step_phi_neg    out  1   1-cycle pulse, phi -1 step
//  busy            out  1   high in every state except IDLE and DONE
//  done            out  1   1-cycle pulse on manual target reached
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; theta_actual = phi_actual = 0; latched samples/targets and timer = 0.
//  - States: IDLE, SAMPLE, CALC, STEP_T, STEP_P, SETTLE, DONE.
//  - IDLE, start=1:
//    - mode_manual=0 -> SAMPLE, s=1.
//    - mode_manual=1 -> latch targets clamped to [0,MAX], then STEP_T, s=2.
//  - SAMPLE: sens_ready=1. On sens_valid&sens_ready, latch all four LDR inputs -> CALC.
//  - CALC (1 cycle): per axis, compare in DW+1 bits unsigned.
//    - R1 > R2+DEADBAND -> dir +.
//    - R2 > R1+DEADBAND -> dir -.
//    - else hold.
//    - Dir is forced to hold if stepping would pass 0 or MAX.
//    - Then -> STEP_T.
//  - STEP_T / STEP_P: timer counts STEP_DIV cycles. On the last cycle:
//    - If the axis needs a step, pulse the matching step_* output and update *_actual +/-1 on the same clock edge (pulse and new value visible together).
//    - Auto: one slot per axis per pass. STEP_T -> STEP_P -> SETTLE. A held axis still consumes its slot, with no pulse.
//    - Manual: stay in STEP_T until theta_actual == target, then STEP_P until phi_actual == target, then DONE with done=1 for 1 cycle. An axis already on target skips its state with no slot.
//  - SETTLE: wait SETTLE_CYC cycles -> SAMPLE.
//  - DONE: hold, s=2, busy=0; start=0 -> IDLE.
//  - start=0 in any non-IDLE state:
//    - Next state is IDLE, s=0.
//    - Step pulse suppressed that cycle; positions retained.
//    - Timer cleared.
//    - A pending sample is not accepted.
//  - Never two step pulses in one cycle; pos and neg of one axis are never both asserted.
//  - rst mid-operation: immediate return to reset values, positions included.
//  - Targets above MAX clamp to MAX. No wrap-around on positions, ever.
// STRUCTURE
//  - tracker_pkg: state enum, s codes (S_IDLE=0, S_AUTO=1, S_MANUAL=2), direction enum (HOLD, POS, NEG).
//  - Sub-module step_timer: load/count/terminal-count pulse.
//    - Shared by the step slots (period STEP_DIV) and SETTLE (period SETTLE_CYC).
//    - Width $clog2(max(STEP_DIV,SETTLE_CYC))+1.
// TESTING (STEP_DIV=4, SETTLE_CYC=8, DEADBAND=4, THETA_MAX=20, PHI_MAX=10)
//  1. rst=1 for 2 cycles, then start=0 -> all outputs 0, s=0, sens_ready=0.
//  2. Manual, theta_manual=3, phi_manual=2, start=1:
//     - required: 3 step_theta_pos pulses 4 clocks apart, then 2 step_phi_pos pulses.
//     - required: theta_actual=3, phi_actual=2, done pulse, s=2.
//  3. Auto, Rv1=30, Rv2=20, Rh1=5, Rh2=15, one valid sample:
//     - required: one step_theta_pos, then one step_phi_neg suppressed (phi=0 limit).
//     - required: 8-cycle SETTLE, then sens_ready=1 again.
//  4. Auto, Rv1=22, Rv2=20 (in deadband), Rh1=Rh2=9 -> no step pulses; positions unchanged.
//  5. Manual theta_manual=50 -> stops at theta_actual=20 (clamped).
//  6. Drop start mid STEP_T, on the slot's last cycle -> no pulse, IDLE next cycle, position kept.
//     Also: sens_valid held high while not in SAMPLE -> not accepted.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types for the solar-tracker sequencer.
//   state_e : sequencer FSM states
//   dir_e   : per-axis step decision
//   S_*     : codes driven on the s output toward the motion datapath
package tracker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CALC,
    ST_STEP_T,
    ST_STEP_P,
    ST_SETTLE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_POS,
    DIR_NEG
  } dir_e;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_AUTO   = 2'd1;
  localparam logic [1:0] S_MANUAL = 2'd2;

endpackage

// File: rtl/tracker_sequencer_step_timer.sv
// Slot timer shared by the step slots and the settle wait.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : return the counter to its idle (zero) value
//   en_i      : count this cycle
//   period_i  : slot length in clocks (>=1)
//   tc_o      : high on the last enabled cycle of the slot
// A zero count means "no slot in progress": the first enabled cycle loads
// period-1 and the counter runs down to 1, where the terminal count fires
// and the counter drops back to zero, ready for the next slot.
module step_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] period_i,
  output logic          tc_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        if (period_i <= TW'(1)) begin
          tc_o = 1'b1;
        end else begin
          cnt_d = period_i - TW'(1);
        end
      end else if (cnt_q == TW'(1)) begin
        tc_o  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tracker_sequencer.sv
// Two-axis (theta/phi) solar-tracker positioning sequencer.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : level, tracking enabled
//   mode_manual              : 1 manual / 0 auto, sampled on IDLE exit
//   sens_valid / sens_ready  : LDR sample handshake
//   R_vertical_1/2           : theta+ / theta- LDRs
//   R_horizontal_1/2         : phi+ / phi- LDRs
//   theta_manual, phi_manual : manual targets, sampled on IDLE exit
//   s                        : 0 idle, 1 auto, 2 manual
//   theta_actual, phi_actual : current positions in steps
//   step_*                   : one-cycle step pulses
//   busy, done               : activity flag, manual-complete pulse
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_SAMPLE | sens_ready high, waiting for an LDR sample
// ST_CALC   | one cycle, derive per-axis direction from latched sample
// ST_STEP_T | theta step slot(s)
// ST_STEP_P | phi step slot(s)
// ST_SETTLE | post-pass wait before resampling (auto)
// ST_DONE   | manual target reached, hold until start drops
module tracker_sequencer
  import tracker_pkg::*;
#(
  parameter int DW         = 16,
  parameter int DEADBAND   = 4,
  parameter int STEP_DIV   = 1000,
  parameter int SETTLE_CYC = 50000,
  parameter int THETA_MAX  = 180,
  parameter int PHI_MAX    = 90
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode_manual,
  input  logic          sens_valid,
  output logic          sens_ready,
  input  logic [DW-1:0] R_vertical_1,
  input  logic [DW-1:0] R_vertical_2,
  input  logic [DW-1:0] R_horizontal_1,
  input  logic [DW-1:0] R_horizontal_2,
  input  logic [DW-1:0] theta_manual,
  input  logic [DW-1:0] phi_manual,
  output logic [1:0]    s,
  output logic [DW-1:0] theta_actual,
  output logic [DW-1:0] phi_actual,
  output logic          step_theta_pos,
  output logic          step_theta_neg,
  output logic          step_phi_pos,
  output logic          step_phi_neg,
  output logic          busy,
  output logic          done
);

  localparam int TMAX = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] STEP_PERIOD   = TW'(STEP_DIV);
  localparam logic [TW-1:0] SETTLE_PERIOD = TW'(SETTLE_CYC);
  localparam logic [DW-1:0] TH_LIM        = DW'(THETA_MAX);
  localparam logic [DW-1:0] PH_LIM        = DW'(PHI_MAX);
  localparam logic [DW:0]   DB_EXT        = (DW+1)'(DEADBAND);

  // Compare one extra bit wide so R+DEADBAND cannot wrap.
  function automatic dir_e axis_dir(input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                                    input logic [DW-1:0] pos, input logic [DW-1:0] lim);
    logic [DW:0] a;
    logic [DW:0] b;
    dir_e        d;
    a = {1'b0, r1};
    b = {1'b0, r2};
    d = DIR_HOLD;
    if (a > b + DB_EXT)      d = DIR_POS;
    else if (b > a + DB_EXT) d = DIR_NEG;
    if (d == DIR_POS && pos >= lim) d = DIR_HOLD;
    if (d == DIR_NEG && pos == '0)  d = DIR_HOLD;
    return d;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v, input logic [DW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_e        state_q, state_d;
  dir_e          dir_t_q, dir_t_d, dir_p_q, dir_p_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] rv1_q, rv1_d, rv2_q, rv2_d, rh1_q, rh1_d, rh2_q, rh2_d;
  logic [DW-1:0] theta_tgt_q, theta_tgt_d, phi_tgt_q, phi_tgt_d;
  logic [DW-1:0] theta_q, theta_d, phi_q, phi_d;
  logic          tp_q, tp_d, tn_q, tn_d, pp_q, pp_d, pn_q, pn_d;
  logic          done_q, done_d;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_period;

  step_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .period_i (tmr_period),
    .tc_o     (tmr_tc)
  );

  // Gating with start keeps a sample from being taken on the abort cycle.
  assign sens_ready = (state_q == ST_SAMPLE) && start;

  always_comb begin
    state_d     = state_q;
    dir_t_d     = dir_t_q;
    dir_p_d     = dir_p_q;
    mode_d      = mode_q;
    rv1_d       = rv1_q;
    rv2_d       = rv2_q;
    rh1_d       = rh1_q;
    rh2_d       = rh2_q;
    theta_tgt_d = theta_tgt_q;
    phi_tgt_d   = phi_tgt_q;
    theta_d     = theta_q;
    phi_d       = phi_q;
    tp_d        = 1'b0;
    tn_d        = 1'b0;
    pp_d        = 1'b0;
    pn_d        = 1'b0;
    done_d      = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    tmr_period  = STEP_PERIOD;

    if (state_q != ST_IDLE && !start) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d = mode_manual;
            if (mode_manual) begin
              theta_tgt_d = clamp(theta_manual, TH_LIM);
              phi_tgt_d   = clamp(phi_manual, PH_LIM);
              state_d     = ST_STEP_T;
            end else begin
              state_d = ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (sens_valid) begin
            rv1_d   = R_vertical_1;
            rv2_d   = R_vertical_2;
            rh1_d   = R_horizontal_1;
            rh2_d   = R_horizontal_2;
            state_d = ST_CALC;
          end
        end
        ST_CALC: begin
          dir_t_d = axis_dir(rv1_q, rv2_q, theta_q, TH_LIM);
          dir_p_d = axis_dir(rh1_q, rh2_q, phi_q, PH_LIM);
          state_d = ST_STEP_T;
        end
        ST_STEP_T: begin
          if (mode_q) begin
            if (theta_q == theta_tgt_q) begin
              state_d = ST_STEP_P;
            end else begin
              tmr_en = 1'b1;
              if (tmr_tc) begin
                if (theta_q < theta_tgt_q) begin
                  theta_d = theta_q + DW'(1);
                  tp_d    = 1'b1;
                end else begin
                  theta_d = theta_q - DW'(1);
                  tn_d    = 1'b1;
                end
                if (theta_d == theta_tgt_q) state_d = ST_STEP_P;
              end
            end
          end else begin
            tmr_en = 1'b1;
            if (tmr_tc) begin
              if (dir_t_q == DIR_POS) begin
                theta_d = theta_q + DW'(1);
                tp_d    = 1'b1;
              end else if (dir_t_q == DIR_NEG) begin
                theta_d = theta_q - DW'(1);
                tn_d    = 1'b1;
              end
              state_d = ST_STEP_P;
            end
          end
        end
        ST_STEP_P: begin
          if (mode_q) begin
            if (phi_q == phi_tgt_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              tmr_en = 1'b1;
              if (tmr_tc) begin
                if (phi_q < phi_tgt_q) begin
                  phi_d = phi_q + DW'(1);
                  pp_d  = 1'b1;
                end else begin
                  phi_d = phi_q - DW'(1);
                  pn_d  = 1'b1;
                end
                if (phi_d == phi_tgt_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                end
              end
            end
          end else begin
            tmr_en = 1'b1;
            if (tmr_tc) begin
              if (dir_p_q == DIR_POS) begin
                phi_d = phi_q + DW'(1);
                pp_d  = 1'b1;
              end else if (dir_p_q == DIR_NEG) begin
                phi_d = phi_q - DW'(1);
                pn_d  = 1'b1;
              end
              state_d = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          tmr_en     = 1'b1;
          tmr_period = SETTLE_PERIOD;
          if (tmr_tc) state_d = ST_SAMPLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_t_q     <= DIR_HOLD;
      dir_p_q     <= DIR_HOLD;
      mode_q      <= 1'b0;
      rv1_q       <= '0;
      rv2_q       <= '0;
      rh1_q       <= '0;
      rh2_q       <= '0;
      theta_tgt_q <= '0;
      phi_tgt_q   <= '0;
      theta_q     <= '0;
      phi_q       <= '0;
      tp_q        <= 1'b0;
      tn_q        <= 1'b0;
      pp_q        <= 1'b0;
      pn_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_t_q     <= dir_t_d;
      dir_p_q     <= dir_p_d;
      mode_q      <= mode_d;
      rv1_q       <= rv1_d;
      rv2_q       <= rv2_d;
      rh1_q       <= rh1_d;
      rh2_q       <= rh2_d;
      theta_tgt_q <= theta_tgt_d;
      phi_tgt_q   <= phi_tgt_d;
      theta_q     <= theta_d;
      phi_q       <= phi_d;
      tp_q        <= tp_d;
      tn_q        <= tn_d;
      pp_q        <= pp_d;
      pn_q        <= pn_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE: s = S_IDLE;
      ST_DONE: s = S_MANUAL;
      default: s = mode_q ? S_MANUAL : S_AUTO;
    endcase
  end

  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = done_q;
  assign theta_actual   = theta_q;
  assign phi_actual     = phi_q;
  assign step_theta_pos = tp_q;
  assign step_theta_neg = tn_q;
  assign step_phi_pos   = pp_q;
  assign step_phi_neg   = pn_q;

endmodule
